// File: rtl/dmem_pkg.sv
// ----------------------------------------------------------------------------
// dmem_pkg: shared state encoding and bus size codes for dmem_bridge. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package dmem_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_ADDR = 2'd1;
   localparam state_t ST_DATA = 2'd2;
   localparam state_t ST_DONE = 2'd3;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

`default_nettype wire

// File: rtl/dmem_strb_dec.sv
// ----------------------------------------------------------------------------
// dmem_strb_dec: big-endian byte strobe -> {wr, size, addr[1:0]}. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dmem_strb_dec
   import dmem_pkg::*;
(
   input  logic [3:0] strb,
   output logic       wr,
   output logic [1:0] size,
   output logic [1:0] addr_lo
);

   always_comb begin
      wr      = (strb != 4'b0000);
      size    = SZ_WORD;
      addr_lo = 2'b00;
      // Strobe bit 3 is byte offset 0; irregular patterns fall back to a word access.
      case (strb)
         4'b1100: size = SZ_HALF;
         4'b0011: begin size = SZ_HALF; addr_lo = 2'b10; end
         4'b1000: size = SZ_BYTE;
         4'b0100: begin size = SZ_BYTE; addr_lo = 2'b01; end
         4'b0010: begin size = SZ_BYTE; addr_lo = 2'b10; end
         4'b0001: begin size = SZ_BYTE; addr_lo = 2'b11; end
         default: begin size = SZ_WORD; addr_lo = 2'b00; end
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/dmem_bridge.sv
// ----------------------------------------------------------------------------
// dmem_bridge: MEM-stage strobe requests onto the req/addr_ok/data_ok bus.
// Option macro DMEM_BRIDGE_WBUF_EN enables posted writes. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dmem_bridge
   import dmem_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          mem_en,
   input  logic [3:0]    mem_wstrb,
   input  logic [AW-1:0] mem_addr,
   input  logic [DW-1:0] mem_wdata,
   output logic [DW-1:0] mem_rdata,
   output logic          mem_stall,
   output logic          data_req,
   output logic          data_wr,
   output logic [1:0]    data_size,
   output logic [AW-1:0] data_addr,
   output logic [DW-1:0] data_wdata,
   input  logic          data_addr_ok,
   input  logic          data_data_ok,
   input  logic [DW-1:0] data_rdata
);

   state_t        state_q, state_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic          dec_wr;
   logic [1:0]    dec_size;
   logic [1:0]    dec_addr_lo;
   logic          issue_ok;
   logic          posted;

   dmem_strb_dec u_strb_dec (
      .strb    (mem_wstrb),
      .wr      (dec_wr),
      .size    (dec_size),
      .addr_lo (dec_addr_lo)
   );

`ifdef DMEM_BRIDGE_WBUF_EN
   logic wr_pending_q, wr_pending_d;

   always_comb begin
      issue_ok = !wr_pending_q;
      posted   = dec_wr;
   end

   // A new posted store outranks a data_ok, which cannot belong to it yet.
   always_comb begin
      wr_pending_d = wr_pending_q;
      if (data_data_ok)
         wr_pending_d = 1'b0;
      if (data_req && data_addr_ok && posted)
         wr_pending_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst)
         wr_pending_q <= 1'b0;
      else
         wr_pending_q <= wr_pending_d;
   end
`else
   always_comb begin
      issue_ok = 1'b1;
      posted   = 1'b0;
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (mem_en && issue_ok)
               state_d = data_addr_ok ? (posted ? ST_DONE : ST_DATA) : ST_ADDR;
         end
         ST_ADDR: begin
            if (data_addr_ok)
               state_d = posted ? ST_DONE : ST_DATA;
         end
         ST_DATA: begin
            if (data_data_ok)
               state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      data_req  = ((state_q == ST_IDLE) && mem_en && issue_ok) || (state_q == ST_ADDR);
      mem_stall = mem_en && (state_q != ST_DONE);
      rdata_d   = rdata_q;
      if ((state_q == ST_DATA) && data_data_ok && !dec_wr)
         rdata_d = data_rdata;
   end

   assign data_wr    = dec_wr;
   assign data_size  = dec_size;
   assign data_addr  = {mem_addr[AW-1:2], dec_addr_lo};
   assign data_wdata = mem_wdata;
   assign mem_rdata  = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_bridge.sv
// ----------------------------------------------------------------------------
// tb_dmem_bridge: scoreboard bench for dmem_bridge. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_dmem_bridge;
   import dmem_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        mem_en = 1'b0;
   logic [3:0]  mem_wstrb = 4'b0;
   logic [31:0] mem_addr = '0;
   logic [31:0] mem_wdata = '0;
   logic [31:0] mem_rdata;
   logic        mem_stall;
   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_addr_ok = 1'b0;
   logic        data_data_ok = 1'b0;
   logic [31:0] data_rdata = '0;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic        wr;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] last_rd = '0;

   dmem_bridge #(.AW(32), .DW(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .mem_en       (mem_en),
      .mem_wstrb    (mem_wstrb),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .mem_stall    (mem_stall),
      .data_req     (data_req),
      .data_wr      (data_wr),
      .data_size    (data_size),
      .data_addr    (data_addr),
      .data_wdata   (data_wdata),
      .data_addr_ok (data_addr_ok),
      .data_data_ok (data_data_ok),
      .data_rdata   (data_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One MEM-stage op; the bench walks its own phase model (0 addr, 1 data, 2 done).
   task automatic do_op(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] wdata,
                        input int a_dly, input int d_dly, input logic [31:0] rdata,
                        input logic [1:0] exp_size, input logic [31:0] exp_addr);
      exp_t e;
      int   phase;
      int   cnt;
      logic post;
      phase     = 0;
      cnt       = 0;
      mem_en    = 1'b1;
      mem_wstrb = strb;
      mem_addr  = addr;
      mem_wdata = wdata;
      e.wr      = (strb != 4'b0);
      e.size    = exp_size;
      e.addr    = exp_addr;
      e.wdata   = wdata;
      if (strb == 4'b0)
         last_rd = rdata;
      e.rdata   = last_rd;
      sb.push_back(e);
      post = 1'b0;
`ifdef DMEM_BRIDGE_WBUF_EN
      post = e.wr;
`endif
      for (int cyc = 0; cyc < 64; cyc++) begin
         data_addr_ok = (phase == 0) && (cnt == a_dly);
         data_data_ok = (phase == 1) && (cnt == d_dly);
         if (phase == 2 && post)
            data_data_ok = 1'b1;
         data_rdata = data_data_ok ? rdata : (32'hBAD0_0000 | 32'(cyc));
         #1;
         chk("stall", {31'b0, mem_stall}, {31'b0, phase != 2});
         chk("req", {31'b0, data_req}, {31'b0, phase == 0});
         if (phase == 0) begin
            chk("wr", {31'b0, data_wr}, {31'b0, sb[0].wr});
            chk("size", {30'b0, data_size}, {30'b0, sb[0].size});
            chk("addr", data_addr, sb[0].addr);
            chk("wdata", data_wdata, sb[0].wdata);
         end
         if (phase == 2) begin
            e = sb.pop_front();
            chk("rdata", mem_rdata, e.rdata);
            break;
         end
         if (phase == 0 && data_addr_ok) begin
            phase = post ? 2 : 1;
            cnt   = 0;
         end else if (phase == 1 && data_data_ok) begin
            phase = 2;
            cnt   = 0;
         end else begin
            cnt++;
         end
         @(posedge clk);
         #1;
      end
      tick();
      mem_en       = 1'b0;
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      tick();
      tick();
      chk("rst_req", {31'b0, data_req}, 32'd0);
      chk("rst_stall", {31'b0, mem_stall}, 32'd0);
      chk("rst_rdata", mem_rdata, 32'd0);
      rst = 1'b1;
      tick();

      // Load followed back-to-back by stores of every regular strobe shape.
      do_op(32'h0000_1004, 4'b0000, 32'h0, 0, 0, 32'hDEAD_BEEF, SZ_WORD, 32'h0000_1004);
      do_op(32'h0000_2000, 4'b0010, 32'h5555_5555, 0, 1, 32'h0, SZ_BYTE, 32'h0000_2002);
      do_op(32'h0000_3000, 4'b0011, 32'hA5A5_A5A5, 3, 0, 32'h0, SZ_HALF, 32'h0000_3002);
      do_op(32'h0000_5003, 4'b1111, $urandom, $urandom_range(0, 2), $urandom_range(0, 2), 32'h0, SZ_WORD, 32'h0000_5000);
      do_op(32'h0000_5101, 4'b1100, $urandom, $urandom_range(0, 2), $urandom_range(0, 2), 32'h0, SZ_HALF, 32'h0000_5100);
      do_op(32'h0000_5203, 4'b1000, $urandom, 1, 0, 32'h0, SZ_BYTE, 32'h0000_5200);
      do_op(32'h0000_5300, 4'b0100, $urandom, 0, 2, 32'h0, SZ_BYTE, 32'h0000_5301);
      do_op(32'h0000_5400, 4'b0001, $urandom, 2, 1, 32'h0, SZ_BYTE, 32'h0000_5403);
      do_op(32'h0000_5502, 4'b1010, $urandom, 0, 0, 32'h0, SZ_WORD, 32'h0000_5500);
      do_op(32'h0000_6007, 4'b0000, 32'h0, 2, 2, 32'h1234_5678, SZ_WORD, 32'h0000_6004);

      // Stray data_ok while idle must not touch the load register.
      data_data_ok = 1'b1;
      data_rdata   = 32'hFFFF_0000;
      tick();
      data_data_ok = 1'b0;
      #1;
      chk("stray_rdata", mem_rdata, last_rd);
      chk("stray_req", {31'b0, data_req}, 32'd0);
      chk("stray_stall", {31'b0, mem_stall}, 32'd0);

      // Reset while waiting in DATA.
      tick();
      mem_en       = 1'b1;
      mem_wstrb    = 4'b0;
      mem_addr     = 32'h0000_7000;
      data_addr_ok = 1'b1;
      #1;
      chk("abort_req0", {31'b0, data_req}, 32'd1);
      tick();
      data_addr_ok = 1'b0;
      #1;
      chk("abort_data_stall", {31'b0, mem_stall}, 32'd1);
      chk("abort_data_req", {31'b0, data_req}, 32'd0);
      rst = 1'b0;
      tick();
      rst    = 1'b1;
      mem_en = 1'b0;
      last_rd = 32'h0;
      #1;
      chk("abort_req", {31'b0, data_req}, 32'd0);
      chk("abort_stall", {31'b0, mem_stall}, 32'd0);
      chk("abort_rdata", mem_rdata, 32'd0);
      data_data_ok = 1'b1;
      data_rdata   = 32'hCAFE_F00D;
      tick();
      data_data_ok = 1'b0;
      #1;
      chk("late_rdata", mem_rdata, 32'd0);
      chk("late_req", {31'b0, data_req}, 32'd0);
      tick();
      do_op(32'h0000_7000, 4'b0000, 32'h0, 1, 1, 32'h0BAD_F00D, SZ_WORD, 32'h0000_7000);

`ifdef DMEM_BRIDGE_WBUF_EN
      // Posted store, then a load held until the write completes.
      mem_en       = 1'b1;
      mem_wstrb    = 4'b1111;
      mem_addr     = 32'h0000_8000;
      mem_wdata    = 32'h1357_9BDF;
      data_addr_ok = 1'b1;
      #1;
      chk("wb_req0", {31'b0, data_req}, 32'd1);
      chk("wb_stall0", {31'b0, mem_stall}, 32'd1);
      tick();
      data_addr_ok = 1'b0;
      #1;
      chk("wb_stall1", {31'b0, mem_stall}, 32'd0);
      tick();
      mem_wstrb = 4'b0;
      mem_addr  = 32'h0000_9000;
      for (int c = 2; c <= 4; c++) begin
         data_data_ok = (c == 4);
         #1;
         chk("wb_hold_req", {31'b0, data_req}, 32'd0);
         chk("wb_hold_stall", {31'b0, mem_stall}, 32'd1);
         tick();
      end
      data_data_ok = 1'b0;
      do_op(32'h0000_9000, 4'b0000, 32'h0, 0, 0, 32'h2468_ACE0, SZ_WORD, 32'h0000_9000);
`endif

      tick();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
